// File: rtl/standby_i2c_bridge_if.sv
// Stream bundle between the I2C target FSM, the TTI queues and the
// standby bridge. The bridge takes the slave side.
interface standby_i2c_bridge_if #(
    parameter int DataWidth = 32
);
    logic                 acq_valid_i;
    logic                 acq_ready_o;
    logic [9:0]           acq_data_i;
    logic                 tx_byte_valid_o;
    logic                 tx_byte_ready_i;
    logic [7:0]           tx_byte_o;
    logic                 rx_desc_valid_o;
    logic                 rx_desc_ready_i;
    logic [31:0]          rx_desc_o;
    logic                 rx_data_valid_o;
    logic                 rx_data_ready_i;
    logic [DataWidth-1:0] rx_data_o;
    logic                 tx_desc_valid_i;
    logic                 tx_desc_ready_o;
    logic [31:0]          tx_desc_i;
    logic                 tx_data_valid_i;
    logic                 tx_data_ready_o;
    logic [DataWidth-1:0] tx_data_i;

    modport slave (
        input  acq_valid_i, acq_data_i, tx_byte_ready_i,
        input  rx_desc_ready_i, rx_data_ready_i,
        input  tx_desc_valid_i, tx_desc_i,
        input  tx_data_valid_i, tx_data_i,
        output acq_ready_o, tx_byte_valid_o, tx_byte_o,
        output rx_desc_valid_o, rx_desc_o,
        output rx_data_valid_o, rx_data_o,
        output tx_desc_ready_o, tx_data_ready_o
    );

    modport master (
        output acq_valid_i, acq_data_i, tx_byte_ready_i,
        output rx_desc_ready_i, rx_data_ready_i,
        output tx_desc_valid_i, tx_desc_i,
        output tx_data_valid_i, tx_data_i,
        input  acq_ready_o, tx_byte_valid_o, tx_byte_o,
        input  rx_desc_valid_o, rx_desc_o,
        input  rx_data_valid_o, rx_data_o,
        input  tx_desc_ready_o, tx_data_ready_o
    );
endinterface

// File: rtl/standby_i2c_bridge.sv
// Standby bridge: packs I2C writes into TTI RX words plus a descriptor,
// and unpacks TTI TX words into read bytes for the target FSM.
module standby_i2c_bridge #(
    parameter int DataWidth = 32,
    parameter int NumAddr   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [7*NumAddr-1:0] addr_i,
    input  logic [7*NumAddr-1:0] mask_i,
    output logic                 err_o,
    standby_i2c_bridge_if.slave  bus
);
    localparam logic [2:0] BLast = 3'(DataWidth / 8 - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_WRITE, RX_DROP, RX_FLUSH, RX_DESC
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE, TX_LOAD, TX_SEND
    } tx_state_e;

    rx_state_e            rx_q, rx_d;
    tx_state_e            tx_q, tx_d;
    logic [15:0]          cnt_q, len_q;
    logic [1:0]           slot_q, hit_idx;
    logic [2:0]           bidx_q, tbidx_q;
    logic                 ovf_q, term_q, pend_vld_q, rdvld_q, err_q;
    logic [7:0]           pend_q, ev_byte;
    logic [DataWidth-1:0] word_q, word_ins, rdata_q, tword_q;
    logic                 hit, open;
    logic                 acq_fire, is_addr, is_stop, is_data;
    logic                 desc_fire, data_fire, byte_fire;
    logic                 unused_desc;

    assign unused_desc = ^bus.tx_desc_i[31:16];

    assign acq_fire = bus.acq_valid_i && bus.acq_ready_o;
    assign is_addr  = bus.acq_data_i[8];
    assign is_stop  = bus.acq_data_i[9:8] == 2'b10;
    assign is_data  = bus.acq_data_i[9:8] == 2'b00;

    assign bus.acq_ready_o = !rst_i && (!enable_i ||
        ((rx_q inside {RX_IDLE, RX_WRITE, RX_DROP}) && !rdvld_q));
    assign bus.rx_data_valid_o = rdvld_q;
    assign bus.rx_data_o       = rdata_q;
    assign bus.rx_desc_valid_o = rx_q == RX_DESC;
    assign bus.rx_desc_o = {12'h000, term_q, ovf_q, slot_q, cnt_q};
    assign err_o = err_q;

    assign desc_fire = bus.tx_desc_valid_i && bus.tx_desc_ready_o;
    assign data_fire = bus.tx_data_valid_i && bus.tx_data_ready_o;
    assign byte_fire = bus.tx_byte_valid_o && bus.tx_byte_ready_i;

    assign bus.tx_desc_ready_o = !rst_i && enable_i && tx_q == TX_IDLE;
    assign bus.tx_data_ready_o = enable_i && tx_q == TX_LOAD;
    assign bus.tx_byte_valid_o = tx_q == TX_SEND;
    assign bus.tx_byte_o       = tword_q[{tbidx_q, 3'b000} +: 8];

    // Address match on the live entry, or on the saved restart in DESC
    always_comb begin
        ev_byte = (rx_q == RX_DESC) ? pend_q : bus.acq_data_i[7:0];
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int k = NumAddr - 1; k >= 0; k--) begin
            if (((ev_byte[7:1] ^ addr_i[7*k +: 7]) & mask_i[7*k +: 7]) == 7'd0) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    // Current accumulation word with the incoming byte inserted
    always_comb begin
        word_ins = word_q;
        word_ins[{bidx_q, 3'b000} +: 8] = bus.acq_data_i[7:0];
    end

    // RX state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rx_q <= RX_IDLE;
        else       rx_q <= rx_d;
    end

    // RX next state; open marks the start of a matched write
    always_comb begin
        rx_d = rx_q;
        open = 1'b0;
        if (!enable_i) begin
            rx_d = RX_IDLE;
        end else begin
            unique case (rx_q)
                RX_IDLE, RX_DROP: begin
                    if (acq_fire && is_addr) begin
                        open = hit && !ev_byte[0];
                        rx_d = open ? RX_WRITE : RX_DROP;
                    end else if (acq_fire && is_stop) begin
                        rx_d = RX_IDLE;
                    end
                end
                RX_WRITE: begin
                    if (acq_fire && !is_data)
                        rx_d = (bidx_q != 3'd0) ? RX_FLUSH : RX_DESC;
                end
                RX_FLUSH: begin
                    if (!rdvld_q) rx_d = RX_DESC;
                end
                RX_DESC: begin
                    if (bus.rx_desc_ready_i) begin
                        if (pend_vld_q) begin
                            open = hit && !ev_byte[0];
                            rx_d = open ? RX_WRITE : RX_DROP;
                        end else begin
                            rx_d = RX_IDLE;
                        end
                    end
                end
                default: rx_d = RX_IDLE;
            endcase
        end
    end

    // RX datapath: packing, count saturation, flush and restart capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || !enable_i) begin
            cnt_q      <= '0;
            slot_q     <= '0;
            bidx_q     <= '0;
            ovf_q      <= 1'b0;
            term_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            rdvld_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (rdvld_q && bus.rx_data_ready_i) rdvld_q <= 1'b0;
            if (open) begin
                slot_q <= hit_idx;
                cnt_q  <= '0;
                bidx_q <= '0;
                word_q <= '0;
                ovf_q  <= 1'b0;
                term_q <= 1'b0;
            end
            if (acq_fire && rx_q == RX_IDLE && !is_addr) err_q <= 1'b1;
            if (acq_fire && rx_q == RX_WRITE) begin
                if (!is_data) begin
                    term_q     <= !is_stop;
                    pend_vld_q <= !is_stop;
                    pend_q     <= bus.acq_data_i[7:0];
                end else if (cnt_q == 16'hFFFF) begin
                    err_q <= !ovf_q;
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                    if (bidx_q == BLast) begin
                        rdata_q <= word_ins;
                        rdvld_q <= 1'b1;
                        word_q  <= '0;
                        bidx_q  <= '0;
                    end else begin
                        word_q <= word_ins;
                        bidx_q <= bidx_q + 3'd1;
                    end
                end
            end
            if (rx_q == RX_FLUSH && !rdvld_q) begin
                rdata_q <= word_q;
                rdvld_q <= 1'b1;
                word_q  <= '0;
                bidx_q  <= '0;
            end
            if (rx_q == RX_DESC && bus.rx_desc_ready_i) pend_vld_q <= 1'b0;
        end
    end

    // TX state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_q <= TX_IDLE;
        else       tx_q <= tx_d;
    end

    // TX next state: descriptor, word load, byte send
    always_comb begin
        tx_d = tx_q;
        if (!enable_i) begin
            tx_d = TX_IDLE;
        end else begin
            unique case (tx_q)
                TX_IDLE: begin
                    if (desc_fire)
                        tx_d = (bus.tx_desc_i[15:0] == 16'd0) ? TX_IDLE : TX_LOAD;
                end
                TX_LOAD: begin
                    if (data_fire) tx_d = TX_SEND;
                end
                TX_SEND: begin
                    if (byte_fire) begin
                        if (len_q == 16'd1)       tx_d = TX_IDLE;
                        else if (tbidx_q == BLast) tx_d = TX_LOAD;
                    end
                end
                default: tx_d = TX_IDLE;
            endcase
        end
    end

    // TX datapath: remaining length, current word and byte index
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || !enable_i) begin
            len_q   <= '0;
            tword_q <= '0;
            tbidx_q <= '0;
        end else begin
            if (desc_fire) len_q <= bus.tx_desc_i[15:0];
            if (data_fire) begin
                tword_q <= bus.tx_data_i;
                tbidx_q <= '0;
            end
            if (byte_fire) begin
                len_q   <= len_q - 16'd1;
                tbidx_q <= tbidx_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_standby_i2c_bridge.sv
// Directed bench for standby_i2c_bridge: RX packing, drop, restart,
// slot mask, TX unpacking, enable, reset and count saturation.
module tb_standby_i2c_bridge;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [13:0] addr_i = {7'h50, 7'h0C};
    logic [13:0] mask_i = {7'h70, 7'h7F};
    logic        err_o;

    standby_i2c_bridge_if #(.DataWidth(32)) bus ();

    standby_i2c_bridge #(.DataWidth(32), .NumAddr(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .enable_i(enable_i),
        .addr_i  (addr_i),
        .mask_i  (mask_i),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rxd_q [$];
    logic [31:0] desc_q [$];
    logic [7:0]  txb_q [$];
    logic [31:0] rxd_last;
    int          rxd_n, err_n, pops, tx_nw;
    logic [31:0] tx_w [4];
    logic        quiet = 1'b0;
    logic        tog = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dq(int i);
        return (i < desc_q.size()) ? desc_q[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] wq(int i);
        return (i < rxd_q.size()) ? rxd_q[i] : 32'hDEADBEEF;
    endfunction

    // RX side monitor; readies are constant so negedge sampling is exact
    always @(negedge clk) begin
        if (bus.rx_data_valid_o && bus.rx_data_ready_i) begin
            rxd_n++;
            rxd_last = bus.rx_data_o;
            if (!quiet) rxd_q.push_back(bus.rx_data_o);
        end
        if (bus.rx_desc_valid_o && bus.rx_desc_ready_i)
            desc_q.push_back(bus.rx_desc_o);
        if (err_o) err_n++;
    end

    // TX data source and byte sink with optional ready toggling
    always @(negedge clk) begin
        if (tog) bus.tx_byte_ready_i = ~bus.tx_byte_ready_i;
        bus.tx_data_valid_i = pops < tx_nw;
        bus.tx_data_i = (pops < tx_nw) ? tx_w[pops[1:0]] : 32'h0;
        if (bus.tx_data_valid_i && bus.tx_data_ready_o) pops++;
        if (bus.tx_byte_valid_o && bus.tx_byte_ready_i)
            txb_q.push_back(bus.tx_byte_o);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] b);
        int n = 0;
        bus.acq_valid_i = 1'b1;
        bus.acq_data_i  = {k, b};
        while (!bus.acq_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.acq_ready_o) chk("acq_timeout", bus.acq_ready_o, 1);
        @(negedge clk);
        bus.acq_valid_i = 1'b0;
    endtask

    task automatic send_desc(input logic [15:0] len);
        int n = 0;
        bus.tx_desc_valid_i = 1'b1;
        bus.tx_desc_i = {16'h0, len};
        while (!bus.tx_desc_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_desc_ready_o) chk("desc_timeout", bus.tx_desc_ready_o, 1);
        @(negedge clk);
        bus.tx_desc_valid_i = 1'b0;
    endtask

    task automatic clr();
        rxd_q.delete();
        desc_q.delete();
        txb_q.delete();
        rxd_n = 0;
        err_n = 0;
        pops  = 0;
    endtask

    localparam logic [1:0] D = 2'b00, S = 2'b01, P = 2'b10, R = 2'b11;

    initial begin
        logic [63:0] bytes;
        rst_i = 1'b1;
        enable_i = 1'b1;
        bus.acq_valid_i = 1'b0;
        bus.acq_data_i = '0;
        bus.tx_desc_valid_i = 1'b0;
        bus.tx_desc_i = '0;
        bus.tx_byte_ready_i = 1'b0;
        bus.rx_desc_ready_i = 1'b1;
        bus.rx_data_ready_i = 1'b1;
        tx_nw = 0;
        clr();
        idle(3);
        chk("rst_acq_ready", bus.acq_ready_o, 0);
        chk("rst_txd_ready", bus.tx_desc_ready_o, 0);
        chk("rst_desc_vld", bus.rx_desc_valid_o, 0);
        rst_i = 1'b0;
        idle(1);
        chk("post_rst_acq", bus.acq_ready_o, 1);

        // Write of 5 bytes with a concurrent 6-byte read
        tx_w[0] = 32'h04030201;
        tx_w[1] = 32'h08070605;
        tx_nw = 2;
        tog = 1'b1;
        fork
            begin
                send(S, 8'h18);
                send(D, 8'h11); send(D, 8'h22); send(D, 8'h33);
                send(D, 8'h44); send(D, 8'h55);
                send(P, 8'h00);
            end
            send_desc(16'd6);
        join
        idle(30);
        chk("w5_nwords", rxd_q.size(), 2);
        chk("w5_word0", wq(0), 32'h44332211);
        chk("w5_word1", wq(1), 32'h00000055);
        chk("w5_desc", dq(0), 32'h00000005);
        bytes = '0;
        foreach (txb_q[i]) bytes = {bytes[55:0], txb_q[i]};
        chk("tx_nbytes", txb_q.size(), 6);
        chk("tx_bytes", bytes, 64'h010203040506);
        chk("tx_pops", pops, 2);
        tog = 1'b0;
        tx_nw = 0;
        clr();

        // Read address is dropped silently
        send(S, 8'h19); send(D, 8'h77); send(P, 8'h00);
        idle(10);
        chk("rd_nwords", rxd_n, 0);
        chk("rd_ndesc", desc_q.size(), 0);
        chk("rd_err", err_n, 0);
        clr();

        // Restart splits one write into two descriptors
        send(S, 8'h18); send(D, 8'hAA); send(R, 8'h18);
        send(D, 8'hBB); send(P, 8'h00);
        idle(10);
        chk("rs_desc0", dq(0), 32'h00080001);
        chk("rs_desc1", dq(1), 32'h00000001);
        chk("rs_word0", wq(0), 32'h000000AA);
        chk("rs_word1", wq(1), 32'h000000BB);
        clr();

        // Slot 1 hit through its partial mask
        send(S, 8'hAA); send(D, 8'h01); send(P, 8'h00);
        idle(10);
        chk("slot1_desc", dq(0), 32'h00010001);
        chk("slot1_word", wq(0), 32'h00000001);
        clr();

        // Stray data in IDLE, then a zero-length write
        send(D, 8'h33);
        idle(3);
        chk("idle_err", err_n, 1);
        send(S, 8'h18); send(P, 8'h00);
        idle(10);
        chk("zero_desc", dq(0), 32'h00000000);
        chk("zero_nwords", rxd_n, 0);
        clr();

        // Zero-length TX descriptor pops nothing
        send_desc(16'd0);
        idle(5);
        chk("tx0_pops", pops, 0);
        chk("tx0_bytes", txb_q.size(), 0);
        chk("tx0_ready", bus.tx_desc_ready_o, 1);
        clr();

        // Disabled: entries are swallowed, TX is blocked
        enable_i = 1'b0;
        #1;
        chk("dis_acq_ready", bus.acq_ready_o, 1);
        chk("dis_txd_ready", bus.tx_desc_ready_o, 0);
        idle(1);
        send(S, 8'h18); send(D, 8'h01); send(P, 8'h00);
        idle(5);
        chk("dis_ndesc", desc_q.size(), 0);
        chk("dis_nwords", rxd_n, 0);
        enable_i = 1'b1;
        idle(2);
        clr();

        // Reset in the middle of a write
        send(S, 8'h18); send(D, 8'h01); send(D, 8'h02); send(D, 8'h03);
        rst_i = 1'b1;
        #1;
        chk("mrst_acq", bus.acq_ready_o, 0);
        chk("mrst_dvld", bus.rx_data_valid_o, 0);
        chk("mrst_desc", bus.rx_desc_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_txd", bus.tx_desc_ready_o, 0);
        idle(2);
        rst_i = 1'b0;
        idle(1);
        send(S, 8'h18); send(P, 8'h00);
        idle(10);
        chk("mrst_newdesc", dq(0), 32'h00000000);
        chk("mrst_nwords", rxd_n, 0);
        clr();

        // Saturating write of 0x10000 bytes
        quiet = 1'b1;
        send(S, 8'h18);
        for (int i = 0; i < 65536; i++) send(D, 8'(i));
        send(P, 8'h00);
        idle(10);
        chk("sat_desc", dq(0), 32'h0004FFFF);
        chk("sat_err", err_n, 1);
        chk("sat_nwords", rxd_n, 16384);
        chk("sat_last", rxd_last, 32'h00FEFDFC);
        quiet = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
